fifo_generator_1: RTL and testbench
===================================

# fifo_generator_1

Single-clock asymmetric FIFO: 8-bit bytes in, 16-bit words out, 256-byte capacity. It buffers a byte stream (e.g. ADC or UART bytes) and hands it to a 16-bit consumer. It reports full/empty flags and occupancy counts on both sides. One clock domain, no clock crossing.

## Interface
- WR_WIDTH, 8, write data width in bits (fixed).
- RD_WIDTH, 16, read data width in bits (fixed, equal to 2 × WR_WIDTH).
- WR_DEPTH, 256, capacity in bytes (power of 2). Read-side capacity is WR_DEPTH/2 = 128 words.
- clk  input  1  single clock; all logic samples on the rising edge.
- srst  input  1  reset, asynchronous and active-low. Low immediately clears the FIFO; release is sampled on clk.
- din  input  8  write byte.
- wr_en  input  1  write request; accepted on a rising edge when full=0.
- rd_en  input  1  read request; accepted on a rising edge when empty=0.
- dout  output  16  read word (registered).
- full  output  1  high when 256 bytes are stored.
- empty  output  1  high when fewer than 2 bytes are stored (no complete word).
- rd_data_count  output  10  complete words stored, 0..128. Bits [9:8] are always 0.
- wr_data_count  output  9  bytes stored, 0..256.

## Operation
- Storage is a 256×8 byte array with a 9-bit write pointer and a 9-bit read pointer (one wrap bit each). Byte occupancy = wr_ptr − rd_ptr, modulo 512.
- Write: on a rising edge with wr_en=1 and full=0, din is stored at wr_ptr[7:0] and wr_ptr increments by 1. A write while full is ignored; no data is lost or overwritten.
- Read: on a rising edge with rd_en=1 and empty=0:
  - dout[15:8] takes the older byte (at rd_ptr).
  - dout[7:0] takes the next byte (at rd_ptr+1).
  - rd_ptr increments by 2.
  - A read while empty is ignored and dout holds its value.
- Byte order: the first byte written ends up in the MSB half of the word.
- Simultaneous accepted write and read on the same edge: both take effect. Net byte occupancy change is +1 − 2 = −1.
- A write accepted while full=1 is impossible, because full is checked before the edge. A read and a write on the same edge while full: the read is accepted and the write is dropped.
- Flags and counts are registered. They reflect occupancy after every edge:
  - full = (occupancy == 256).
  - empty = (occupancy < 2).
  - wr_data_count = occupancy.
  - rd_data_count = occupancy >> 1.
- An odd leftover byte stays stored until its partner byte arrives. While waiting it keeps empty=1 if it is the only byte.
- Pointers wrap naturally modulo 512. No special handling is needed at the array boundary.

## Timing
- Reset (srst=0), asynchronous:
  - pointers = 0, dout = 16'h0000.
  - full = 0, empty = 1.
  - rd_data_count = 0, wr_data_count = 0.
  - wr_en and rd_en are ignored while srst=0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Write latency:
  - wr_data_count increments on the same edge that accepts the byte.
  - empty falls on the edge that stores the 2nd byte.
  - full rises on the edge that stores the 256th byte.
- Read latency: one cycle. dout shows the word on the edge where rd_en is accepted, and is valid from that edge until the next accepted read.
- Flag update: empty and full change on the accepting edge, with no extra latency. Back-to-back reads every cycle run until empty, with no bubbles.
- No underflow or overflow indications. Throughput: one byte written and one word read per cycle.

## Test plan
- Reset: hold srst=0, toggle wr_en/rd_en -> dout=0, empty=1, full=0, both counts 0. Release, then idle 10 cycles -> no change.
- Byte stream: write bytes 0x01..0x64 (100 bytes) on consecutive edges -> wr_data_count=100, rd_data_count=50, empty=0. Then read 50 times -> dout sequence 0x0102, 0x0304, …, 0x6364, empty=1 after the 50th read.
- Odd byte: write 3 bytes (0xA1, 0xA2, 0xA3), then read twice:
  - First read: dout=0xA1A2.
  - Second read: ignored (empty=1), dout stays 0xA1A2, wr_data_count=1.
  - Write 0xA4, then read -> dout=0xA3A4.
- Full/overflow: write 257 bytes -> full=1 after the 256th, wr_data_count=256, rd_data_count=128. The 257th byte is dropped. Read 128 words -> data intact in order, with no sign of byte 257.
- Simultaneous rd/wr with wrap:
  - Fill to 10 bytes, then assert wr_en and rd_en together for 600 cycles with an incrementing byte pattern.
  - Occupancy drops by 1 per cycle until empty, after which only writes proceed.
  - Check byte ordering across pointer wrap and a continuous dout sequence.
- Mid-operation reset: after 50 bytes written, pulse srst=0 between clock edges -> outputs clear immediately. A subsequent write of 0x11, 0x22 and a read -> dout=0x1122.

Source files
------------

// File: rtl/fifo_generator_1.sv
// Single-clock asymmetric FIFO: 256-byte store, 8-bit write side, 16-bit read side.
// The older byte of each pair lands in the upper half of the output word.
module fifo_generator_1 (
    input  logic        clk,
    input  logic        srst,
    input  logic [7:0]  din,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [15:0] dout,
    output logic        full,
    output logic        empty,
    output logic [9:0]  rd_data_count,
    output logic [8:0]  wr_data_count
);

    localparam int WR_WIDTH = 8;
    localparam int RD_WIDTH = 16;
    localparam int WR_DEPTH = 256;
    localparam int ADDR_W   = $clog2(WR_DEPTH);
    localparam int PTR_W    = ADDR_W + 1;

    logic [WR_WIDTH-1:0] mem_r [WR_DEPTH];

    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [RD_WIDTH-1:0] dout_r;
    logic                full_r;
    logic                empty_r;
    logic [8:0]          wr_cnt_r;
    logic [9:0]          rd_cnt_r;

    logic                wr_acc_s;
    logic                rd_acc_s;
    logic [PTR_W-1:0]    wr_ptr_nxt_s;
    logic [PTR_W-1:0]    rd_ptr_nxt_s;
    logic [PTR_W-1:0]    occ_nxt_s;
    logic [ADDR_W-1:0]   rd_addr0_s;
    logic [ADDR_W-1:0]   rd_addr1_s;
    logic [RD_WIDTH-1:0] rd_word_s;

    // Accept decisions, next pointers and the occupancy they imply.
    always_comb begin
        wr_acc_s     = 1'b0;
        rd_acc_s     = 1'b0;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;

        if (wr_en && !full_r) begin
            wr_acc_s     = 1'b1;
            wr_ptr_nxt_s = wr_ptr_r + 9'd1;
        end else begin
            wr_acc_s     = 1'b0;
        end

        if (rd_en && !empty_r) begin
            rd_acc_s     = 1'b1;
            rd_ptr_nxt_s = rd_ptr_r + 9'd2;
        end else begin
            rd_acc_s     = 1'b0;
        end

        // The extra wrap bit keeps 256 (full) distinct from 0 (empty).
        occ_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    end

    // Assemble the outgoing word from the two oldest bytes.
    always_comb begin
        rd_addr0_s = rd_ptr_r[ADDR_W-1:0];
        rd_addr1_s = rd_ptr_r[ADDR_W-1:0] + 8'd1;
        rd_word_s  = {mem_r[rd_addr0_s], mem_r[rd_addr1_s]};
    end

    // Byte storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (srst && wr_acc_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= din;
        end
    end

    // Pointers, output word, flags and counts.
    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            wr_ptr_r <= 9'd0;
            rd_ptr_r <= 9'd0;
            dout_r   <= 16'h0000;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            wr_cnt_r <= 9'd0;
            rd_cnt_r <= 10'd0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            if (rd_acc_s) begin
                dout_r <= rd_word_s;
            end
            full_r   <= (occ_nxt_s == PTR_W'(WR_DEPTH));
            empty_r  <= (occ_nxt_s < 9'd2);
            wr_cnt_r <= occ_nxt_s;
            rd_cnt_r <= {2'b00, occ_nxt_s[8:1]};
        end
    end

    assign dout          = dout_r;
    assign full          = full_r;
    assign empty         = empty_r;
    assign wr_data_count = wr_cnt_r;
    assign rd_data_count = rd_cnt_r;

endmodule

// File: tb/tb_fifo_generator_1.sv
// Directed testbench for fifo_generator_1: reset, streaming, odd bytes,
// full/overflow, simultaneous read/write across pointer wrap, and mid-run reset.
module tb_fifo_generator_1;

    logic        clk;
    logic        srst;
    logic [7:0]  din;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] dout;
    logic        full;
    logic        empty;
    logic [9:0]  rd_data_count;
    logic [8:0]  wr_data_count;

    int n_checks;
    int n_pass;

    fifo_generator_1 dut (
        .clk           (clk),
        .srst          (srst),
        .din           (din),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .dout          (dout),
        .full          (full),
        .empty         (empty),
        .rd_data_count (rd_data_count),
        .wr_data_count (wr_data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given request pattern; returns 1 time unit after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hAA, 1'b1);
        end
        n_checks++; if (dout !== 16'h0000) $display("FAIL reset_dout got %h want 0000", dout); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
        n_checks++; if (wr_data_count !== 9'd0) $display("FAIL reset_wrcnt got %0d want 0", wr_data_count); else n_pass++;
        n_checks++; if (rd_data_count !== 10'd0) $display("FAIL reset_rdcnt got %0d want 0", rd_data_count); else n_pass++;
        srst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0);
        end
        n_checks++; if ({dout, empty, full, wr_data_count} !== {16'h0000, 1'b1, 1'b0, 9'd0})
            $display("FAIL idle_after_reset got dout=%h e=%b f=%b wc=%0d want 0000 1 0 0", dout, empty, full, wr_data_count);
        else n_pass++;
    endtask

    task automatic test_byte_stream();
        logic [15:0] exp;
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 8'(i), 1'b0);
        end
        n_checks++; if (wr_data_count !== 9'd100) $display("FAIL stream_wrcnt got %0d want 100", wr_data_count); else n_pass++;
        n_checks++; if (rd_data_count !== 10'd50) $display("FAIL stream_rdcnt got %0d want 50", rd_data_count); else n_pass++;
        n_checks++; if (empty !== 1'b0) $display("FAIL stream_empty got %b want 0", empty); else n_pass++;
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 8'h00, 1'b1);
            exp = {8'(2 * k + 1), 8'(2 * k + 2)};
            n_checks++; if (dout !== exp) $display("FAIL stream_word%0d got %h want %h", k, dout, exp); else n_pass++;
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL stream_empty_end got %b want 1", empty); else n_pass++;
        n_checks++; if (wr_data_count !== 9'd0) $display("FAIL stream_wrcnt_end got %0d want 0", wr_data_count); else n_pass++;
    endtask

    task automatic test_odd_byte();
        step(1'b1, 8'hA1, 1'b0);
        n_checks++; if (empty !== 1'b1) $display("FAIL odd_empty_1byte got %b want 1", empty); else n_pass++;
        step(1'b1, 8'hA2, 1'b0);
        n_checks++; if (empty !== 1'b0) $display("FAIL odd_empty_2byte got %b want 0", empty); else n_pass++;
        step(1'b1, 8'hA3, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        n_checks++; if (dout !== 16'hA1A2) $display("FAIL odd_read1 got %h want a1a2", dout); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL odd_empty_left1 got %b want 1", empty); else n_pass++;
        step(1'b0, 8'h00, 1'b1);
        n_checks++; if (dout !== 16'hA1A2) $display("FAIL odd_read2_hold got %h want a1a2", dout); else n_pass++;
        n_checks++; if (wr_data_count !== 9'd1) $display("FAIL odd_wrcnt got %0d want 1", wr_data_count); else n_pass++;
        step(1'b1, 8'hA4, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        n_checks++; if (dout !== 16'hA3A4) $display("FAIL odd_read3 got %h want a3a4", dout); else n_pass++;
        n_checks++; if (wr_data_count !== 9'd0) $display("FAIL odd_wrcnt_end got %0d want 0", wr_data_count); else n_pass++;
    endtask

    task automatic test_full();
        logic [15:0] exp;
        for (int k = 0; k < 257; k++) begin
            step(1'b1, 8'(k) ^ 8'hC3, 1'b0);
            if (k == 254) begin
                n_checks++; if (full !== 1'b0) $display("FAIL full_at255 got %b want 0", full); else n_pass++;
            end
            if (k == 255) begin
                n_checks++; if (full !== 1'b1) $display("FAIL full_at256 got %b want 1", full); else n_pass++;
                n_checks++; if (rd_data_count !== 10'd128) $display("FAIL full_rdcnt got %0d want 128", rd_data_count); else n_pass++;
            end
        end
        n_checks++; if (wr_data_count !== 9'd256) $display("FAIL full_wrcnt_after257 got %0d want 256", wr_data_count); else n_pass++;
        for (int k = 0; k < 128; k++) begin
            step(1'b0, 8'h00, 1'b1);
            exp = {8'(2 * k) ^ 8'hC3, 8'(2 * k + 1) ^ 8'hC3};
            n_checks++; if (dout !== exp) $display("FAIL full_word%0d got %h want %h", k, dout, exp); else n_pass++;
            if (k == 0) begin
                n_checks++; if (full !== 1'b0) $display("FAIL full_clear got %b want 0", full); else n_pass++;
            end
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL full_drain_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (wr_data_count !== 9'd0) $display("FAIL full_drain_wrcnt got %0d want 0", wr_data_count); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [7:0]  q[$];
        logic [15:0] exp;
        logic        acc_r;
        logic        acc_w;
        int          seq;
        seq = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(seq), 1'b0);
            q.push_back(8'(seq));
            seq++;
        end
        n_checks++; if (wr_data_count !== 9'd10) $display("FAIL simul_fill got %0d want 10", wr_data_count); else n_pass++;
        for (int c = 0; c < 600; c++) begin
            acc_r = (q.size() >= 2);
            acc_w = (q.size() < 256);
            step(1'b1, 8'(seq), 1'b1);
            if (acc_r) begin
                exp = {q[0], q[1]};
                void'(q.pop_front());
                void'(q.pop_front());
                n_checks++; if (dout !== exp) $display("FAIL simul_word_c%0d got %h want %h", c, dout, exp); else n_pass++;
            end
            if (acc_w) begin
                q.push_back(8'(seq));
                seq++;
            end
            n_checks++; if (wr_data_count !== 9'(q.size())) $display("FAIL simul_cnt_c%0d got %0d want %0d", c, wr_data_count, q.size()); else n_pass++;
            n_checks++; if (empty !== (q.size() < 2)) $display("FAIL simul_empty_c%0d got %b want %b", c, empty, (q.size() < 2)); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 8'(i + 16), 1'b0);
        end
        #2;
        srst = 1'b0;
        #1;
        n_checks++; if (wr_data_count !== 9'd0) $display("FAIL midrst_wrcnt got %0d want 0", wr_data_count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL midrst_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (dout !== 16'h0000) $display("FAIL midrst_dout got %h want 0000", dout); else n_pass++;
        n_checks++; if (rd_data_count !== 10'd0) $display("FAIL midrst_rdcnt got %0d want 0", rd_data_count); else n_pass++;
        #1;
        srst = 1'b1;
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        n_checks++; if (dout !== 16'h1122) $display("FAIL midrst_word got %h want 1122", dout); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL midrst_empty_end got %b want 1", empty); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        srst     = 1'b0;
        din      = 8'h00;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        #1;
        test_reset();
        test_byte_stream();
        test_odd_byte();
        test_full();
        test_simultaneous();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
